arb_resp_router: RTL

- Sits directly downstream of the round-robin arbitration tree, between the arbiter output and a single shared slave port.
- Forwards each granted request to the slave and records the winning input index in an in-order ID FIFO.
- Steers each in-order slave response back to the input that issued it.
- Bounds outstanding transactions to MaxOutstanding by withholding grant from the arbiter when the FIFO is full.

---
 rtl/arb_resp_router_pkg.sv | 15 +
 rtl/arb_resp_router_if.sv | 66 ++++++
 rtl/arb_resp_router_id_fifo.sv | 77 +++++++
 rtl/arb_resp_router.sv | 84 ++++++++
 4 files changed

// File: rtl/arb_resp_router_pkg.sv
// Shared types and helpers for the arbiter response router.
// Occupancy counters need one more code than the depth.
package arb_resp_pkg;

  localparam int unsigned DefNumIn = 4;

  typedef logic [$clog2(DefNumIn)-1:0] idx_t;

  function automatic int unsigned clog2p1(
    input int unsigned n
  );
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/arb_resp_router_if.sv
// Arbiter-side, slave-side and requester-side signals of the router.
// The slave modport is the router's view; master is the environment.
interface arb_resp_router_if #(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned ReqWidth       = 32,
  parameter int unsigned RspWidth       = 32,
  parameter int unsigned MaxOutstanding = 4
);
  import arb_resp_pkg::*;

  localparam int unsigned IdxWidth = $clog2(NumIn);
  localparam int unsigned CntWidth = clog2p1(MaxOutstanding);

  logic                arb_req_i;
  logic [ReqWidth-1:0] arb_data_i;
  logic [IdxWidth-1:0] arb_idx_i;
  logic                arb_gnt_o;
  logic                slv_req_o;
  logic [ReqWidth-1:0] slv_data_o;
  logic                slv_gnt_i;
  logic                slv_rsp_valid_i;
  logic [RspWidth-1:0] slv_rsp_data_i;
  logic                slv_rsp_ready_o;
  logic [NumIn-1:0]    rsp_valid_o;
  logic [RspWidth-1:0] rsp_data_o;
  logic [NumIn-1:0]    rsp_ready_i;
  logic [CntWidth-1:0] outstanding_o;
  logic                orphan_err_o;

  modport slave (
    input  arb_req_i,
    input  arb_data_i,
    input  arb_idx_i,
    output arb_gnt_o,
    output slv_req_o,
    output slv_data_o,
    input  slv_gnt_i,
    input  slv_rsp_valid_i,
    input  slv_rsp_data_i,
    output slv_rsp_ready_o,
    output rsp_valid_o,
    output rsp_data_o,
    input  rsp_ready_i,
    output outstanding_o,
    output orphan_err_o
  );

  modport master (
    output arb_req_i,
    output arb_data_i,
    output arb_idx_i,
    input  arb_gnt_o,
    input  slv_req_o,
    input  slv_data_o,
    output slv_gnt_i,
    output slv_rsp_valid_i,
    output slv_rsp_data_i,
    input  slv_rsp_ready_o,
    input  rsp_valid_o,
    input  rsp_data_o,
    output rsp_ready_i,
    input  outstanding_o,
    input  orphan_err_o
  );

endinterface

// File: rtl/arb_resp_router_id_fifo.sv
// Circular FIFO of winning requester indices, one entry per
// in-flight transaction; depth need not be a power of two.
module arb_resp_id_fifo
  import arb_resp_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush,
  input  logic                         push,
  input  logic [IdxWidth-1:0]          wdata,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [IdxWidth-1:0]          head,
  output logic [clog2p1(Depth)-1:0]    count
);

  localparam int unsigned PtrWidth =
    (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = clog2p1(Depth);

  typedef logic [PtrWidth-1:0] ptr_t;

  logic [IdxWidth-1:0] mem [Depth];
  ptr_t                rd_ptr;
  ptr_t                wr_ptr;
  logic                push_ok;
  logic                pop_ok;

  function automatic ptr_t inc(input ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CntWidth'(Depth));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= inc(wr_ptr);
      if (pop_ok)  rd_ptr <= inc(rd_ptr);
      if (push_ok && !pop_ok)
        count <= count + 1'b1;
      else if (pop_ok && !push_ok)
        count <= count - 1'b1;
    end
  end

  // Payload storage carries no reset; occupancy qualifies it.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  a_no_push_full: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(push && full)
  );

  a_count_max: assert property (
    @(posedge clk_i) disable iff (rst_i)
    count <= CntWidth'(Depth)
  );

endmodule

// File: rtl/arb_resp_router.sv
// Forwards granted arbiter requests to one slave, remembers the
// winner per transaction and steers in-order responses back.
module arb_resp_router
  import arb_resp_pkg::*;
#(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned ReqWidth       = 32,
  parameter int unsigned RspWidth       = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  input logic               flush_i,
  arb_resp_router_if.slave  bus
);

  localparam int unsigned IdxWidth = $clog2(NumIn);
  localparam int unsigned CntWidth = clog2p1(MaxOutstanding);

  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                orphan_q;
  logic [IdxWidth-1:0] head;
  logic [CntWidth-1:0] count;

  arb_resp_id_fifo #(
    .Depth    (MaxOutstanding),
    .IdxWidth (IdxWidth)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (flush_i),
    .push  (push),
    .wdata (bus.arb_idx_i),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head),
    .count (count)
  );

  assign bus.slv_req_o  = bus.arb_req_i & ~full;
  assign bus.slv_data_o = bus.arb_data_i;
  assign bus.arb_gnt_o  = bus.slv_gnt_i & ~full & ~rst_i;
  assign push = bus.arb_req_i & bus.arb_gnt_o;

  // With nothing outstanding, responses are drained as orphans.
  assign bus.slv_rsp_ready_o = empty | bus.rsp_ready_i[head];
  assign bus.rsp_data_o      = bus.slv_rsp_data_i;
  assign pop = bus.slv_rsp_valid_i
             & bus.slv_rsp_ready_o
             & ~empty;

  always_comb begin
    bus.rsp_valid_o = '0;
    if (bus.slv_rsp_valid_i && !empty && !rst_i)
      bus.rsp_valid_o[head] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      orphan_q <= 1'b0;
    else if (flush_i)
      orphan_q <= 1'b0;
    else if (bus.slv_rsp_valid_i && empty)
      orphan_q <= 1'b1;
  end

  assign bus.orphan_err_o  = orphan_q;
  assign bus.outstanding_o = count;

  a_onehot: assert property (
    @(posedge clk_i) disable iff (rst_i)
    $onehot0(bus.rsp_valid_o)
  );

  a_gnt: assert property (
    @(posedge clk_i) disable iff (rst_i)
    bus.arb_gnt_o |-> bus.slv_gnt_i
  );

endmodule
